// File: rtl/pool_window_reader_if.sv
// Bundles the register-file read port, job control and result handshake of the pooling reader.
interface pool_window_reader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              done;

  // Reader side: issues addresses, produces results.
  modport master (
    input  start, base_addr, rd_data, out_ready,
    output rd_addr, busy, out_valid, out_data, done
  );

  // Environment side: register file, job requester and result consumer.
  modport slave (
    output start, base_addr, rd_data, out_ready,
    input  rd_addr, busy, out_valid, out_data, done
  );
endinterface

// File: rtl/pool_window_reader.sv
// Walks NUM_WIN windows of WIN consecutive register-file entries and emits the signed max of each
// window over a valid/ready handshake. Register-file data arrives one cycle after its address.
module pool_window_reader #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned WIN     = 4,
  parameter int unsigned NUM_WIN = 4
) (
  input logic                 clk,
  input logic                 nrst,
  pool_window_reader_if.master bus
);
  localparam int unsigned EW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StLast, StOut} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     elem_q, elem_d;
  logic [WW-1:0]     win_q, win_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic              cap_vld_q, cap_first_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              last_elem, last_win;

  assign last_elem = (elem_q == EW'(WIN - 1));
  assign last_win  = (win_q == WW'(NUM_WIN - 1));

  // Windows are contiguous, so a running pointer equals base + win*WIN + elem (mod 2^ADDR_W).
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ptr_d   = bus.base_addr;
          elem_d  = '0;
          win_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        rd_addr_d = ptr_q;
        ptr_d     = ptr_q + 1'b1;
        if (last_elem) begin
          state_d = StLast;
        end else begin
          elem_d = elem_q + 1'b1;
        end
      end
      StLast: begin
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          if (last_win) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            win_d   = win_q + 1'b1;
            elem_d  = '0;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Running signed max; the first element of a window overwrites, ties keep the old value.
  always_comb begin
    acc_d = acc_q;
    if (cap_vld_q) begin
      if (cap_first_q || ($signed(bus.rd_data) > $signed(acc_q))) begin
        acc_d = bus.rd_data;
      end
    end
  end

  // State, counters, capture pipeline and accumulator.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      win_q       <= '0;
      ptr_q       <= '0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_first_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
      cap_vld_q   <= (state_q == StRead);
      cap_first_q <= (state_q == StRead) && (elem_q == '0);
      acc_q       <= acc_d;
    end
  end

  // Address is live only while reading; otherwise it holds the last address issued.
  always_comb begin
    bus.rd_addr   = (state_q == StRead) ? ptr_q : rd_addr_q;
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (state_q == StOut);
    bus.out_data  = acc_q;
    bus.done      = done_q;
  end
endmodule

// File: tb/tb_pool_window_reader.sv
// Self-checking bench for pool_window_reader: table of jobs plus hand-written corner sequences.
module tb_pool_window_reader;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned WIN     = 4;
  localparam int unsigned NUM_WIN = 4;

  logic clk;
  logic nrst;

  pool_window_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pool_window_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .WIN    (WIN),
    .NUM_WIN(NUM_WIN)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct {
    int unsigned      preset;
    logic [3:0]       base;
    int unsigned      rdy;
    logic [3:0][15:0] exp;
  } vec_t;

  logic [15:0] regs [16];
  logic [15:0] sb [$];
  int          n_chk;
  int          n_err;
  int          done_cnt;
  int          rdy_mode;
  vec_t        vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: one-cycle read latency.
  always @(posedge clk) bus.rd_data <= regs[bus.rd_addr];

  // Downstream ready: 0 = always, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: handshakes pop the scoreboard, done pulses are counted.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.done) begin
        done_cnt++;
        chk("done_in_idle_busy", 32'(bus.busy), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: got %0h want none", bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int unsigned p, input logic [3:0] b, input int unsigned r,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.preset = p;
    v.base   = b;
    v.rdy    = r;
    v.exp[0] = e0;
    v.exp[1] = e1;
    v.exp[2] = e2;
    v.exp[3] = e3;
    return v;
  endfunction

  task automatic fill_regs(input int unsigned p);
    for (int i = 0; i < 16; i++) begin
      case (p)
        0:       regs[i] = 16'(i + 1);
        2:       regs[i] = 16'(0 - i);
        default: regs[i] = 16'h0000;
      endcase
    end
    if (p == 1) begin
      regs[0]  = 16'hFFFB; regs[1]  = 16'hFFFF; regs[2]  = 16'hFFF9; regs[3]  = 16'hFFFD;
      regs[4]  = 16'h8000; regs[5]  = 16'h7FFF; regs[6]  = 16'h0000; regs[7]  = 16'h0001;
      regs[8]  = 16'h8000; regs[9]  = 16'h8000; regs[10] = 16'h8000; regs[11] = 16'h8000;
      regs[12] = 16'h0005; regs[13] = 16'h0005; regs[14] = 16'hFFFE; regs[15] = 16'h0003;
    end
    if (p == 2) begin
      regs[14] = 16'd9; regs[15] = 16'd2; regs[0] = 16'd30; regs[1] = 16'd4;
    end
  endtask

  // Returns in cycle 1 of the job (just after the accepting edge).
  task automatic start_job(input logic [3:0] b);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got no done want done within %0d cycles", name, budget);
    end
  endtask

  task automatic run_vector(input vec_t v);
    int          d0;
    int          lat;
    logic [3:0]  ea;
    rdy_mode = int'(v.rdy);
    fill_regs(v.preset);
    for (int i = 0; i < 4; i++) sb.push_back(v.exp[i]);
    d0  = done_cnt;
    lat = 0;
    start_job(v.base);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= int'(WIN)) begin
        ea = v.base + 4'(c - 1);
        chk("rd_addr_seq", 32'(bus.rd_addr), 32'(ea));
      end else if (c == int'(WIN) + 1) begin
        ea = v.base + 4'(WIN - 1);
        chk("rd_addr_hold_last", 32'(bus.rd_addr), 32'(ea));
      end
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    chk("first_valid_cycle", 32'(lat), 32'(WIN + 2));
    wait_done("job_done", 300);
    @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] snap_d;
    logic [3:0]  snap_a;
    int          d0;
    bit          seen;
    n_chk         = 0;
    n_err         = 0;
    done_cnt      = 0;
    rdy_mode      = 0;
    nrst          = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    fill_regs(0);

    vecs[0] = mk(0, 4'd0,  0, 16'd4,     16'd8,     16'd12,    16'd16);
    vecs[1] = mk(1, 4'd0,  0, 16'hFFFF,  16'h7FFF,  16'h8000,  16'h0005);
    vecs[2] = mk(2, 4'd14, 0, 16'h001E,  16'hFFFE,  16'hFFFA,  16'hFFF6);
    vecs[3] = mk(0, 4'd14, 1, 16'd16,    16'd6,     16'd10,    16'd14);
    vecs[4] = mk(1, 4'd4,  1, 16'h7FFF,  16'h8000,  16'h0005,  16'hFFFF);

    // Reset values.
    #12;
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Backpressure: ready held low for 10 cycles while a result is waiting.
    rdy_mode = 2;
    fill_regs(0);
    sb.push_back(16'd4); sb.push_back(16'd8); sb.push_back(16'd12); sb.push_back(16'd16);
    start_job(4'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    snap_d = bus.out_data;
    snap_a = bus.rd_addr;
    chk("bp_first_value", 32'(snap_d), 32'd4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid_stable", 32'(bus.out_valid), 32'd1);
      chk("bp_data_stable", 32'(bus.out_data), 32'(snap_d));
      chk("bp_addr_stable", 32'(bus.rd_addr), 32'(snap_a));
    end
    rdy_mode = 0;
    wait_done("bp_done", 300);
    @(posedge clk);
    #1;
    chk("bp_sb_drained", 32'(sb.size()), 32'd0);

    // Start while busy is ignored; start in the done cycle launches a new job.
    rdy_mode = 0;
    fill_regs(0);
    d0 = done_cnt;
    sb.push_back(16'd4); sb.push_back(16'd8); sb.push_back(16'd12); sb.push_back(16'd16);
    start_job(4'd0);
    repeat (3) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = 4'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start_done", 300);
    sb.push_back(16'd8); sb.push_back(16'd12); sb.push_back(16'd16); sb.push_back(16'd4);
    bus.start     = 1'b1;
    bus.base_addr = 4'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_done", 300);
    @(posedge clk);
    #1;
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of window 2 (third window).
    fill_regs(0);
    sb.push_back(16'd4); sb.push_back(16'd8); sb.push_back(16'd12); sb.push_back(16'd16);
    start_job(4'd0);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk("mid_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_idle", 32'(bus.busy), 32'd0);
    run_vector(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
